// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// The carry chain is cut into STAGES segments; each stage adds its own segment.
module cla_pipe #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEG  = (WIDTH + STAGES - 1) / STAGES;
  localparam int unsigned LAST = STAGES - 1;
  // Operand and MSB-carry storage is only needed ahead of the final stage.
  localparam int unsigned PIPE = (STAGES > 1) ? STAGES - 1 : 1;

  if (WIDTH < 4 || WIDTH > 64 || GROUP < 1 || STAGES < 1 || STAGES > 4 ||
      STAGES > WIDTH / GROUP) begin : g_bad_param
    $error("cla_pipe: illegal parameter combination");
  end

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] ld_c;
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [PIPE];
  logic [WIDTH-1:0]  a_d [PIPE];
  logic [WIDTH-1:0]  b_q [PIPE];
  logic [WIDTH-1:0]  b_d [PIPE];
  logic [PIPE-1:0]   m_q, m_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  function automatic int seg_lo(input int k);
    return k * int'(SEG);
  endfunction

  function automatic int seg_hi(input int k);
    int hi;
    hi = (k + 1) * int'(SEG);
    if (hi > int'(WIDTH)) hi = int'(WIDTH);
    return hi;
  endfunction

  // A stage loads when it is empty or everything downstream of it can move.
  always_comb begin : p_load
    logic go;
    go   = out_ready;
    ld_c = '0;
    for (int k = int'(LAST); k >= 0; k--) begin
      go      = go | ~v_q[k];
      ld_c[k] = go;
    end
  end

  assign in_ready = ld_c[0] | rst;

  always_comb begin : p_datapath
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic c_in, m_in, v_in;
    logic gc, cc, grp_g, grp_p, bit_g, bit_p;
    int   lo, hi;
    v_d    = v_q;
    s_d    = s_q;
    c_d    = c_q;
    a_d    = a_q;
    b_d    = b_q;
    m_d    = m_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    a_in   = '0;
    b_in   = '0;
    s_in   = '0;
    c_in   = 1'b0;
    m_in   = 1'b0;
    v_in   = 1'b0;
    gc     = 1'b0;
    cc     = 1'b0;
    grp_g  = 1'b0;
    grp_p  = 1'b1;
    bit_g  = 1'b0;
    bit_p  = 1'b0;
    lo     = 0;
    hi     = 0;
    for (int k = 0; k < int'(STAGES); k++) begin
      if (k == 0) begin
        a_in = op_a;
        b_in = op_b ^ {WIDTH{sub}};
        s_in = '0;
        c_in = cin ^ sub;
        m_in = 1'b0;
        v_in = in_valid;
      end else begin
        a_in = a_q[k-1];
        b_in = b_q[k-1];
        s_in = s_q[k-1];
        c_in = c_q[k-1];
        m_in = m_q[k-1];
        v_in = v_q[k-1];
      end
      lo = seg_lo(k);
      hi = seg_hi(k);
      // Group P/G inside the segment; gc is the second-level carry between groups.
      gc    = c_in;
      cc    = c_in;
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i >= lo && i < hi) begin
          if ((i - lo) % int'(GROUP) == 0) begin
            cc    = gc;
            grp_g = 1'b0;
            grp_p = 1'b1;
          end
          bit_g   = a_in[i] & b_in[i];
          bit_p   = a_in[i] ^ b_in[i];
          s_in[i] = bit_p ^ cc;
          if (i == int'(WIDTH) - 1) m_in = cc;
          cc      = bit_g | (bit_p & cc);
          grp_g   = bit_g | (bit_p & grp_g);
          grp_p   = grp_p & bit_p;
          if ((i - lo) % int'(GROUP) == int'(GROUP) - 1 || i == hi - 1) begin
            gc = grp_g | (grp_p & gc);
          end
        end
      end
      v_d[k] = ld_c[k] ? v_in : v_q[k];
      if (ld_c[k] && v_in) begin
        s_d[k] = s_in;
        c_d[k] = gc;
        if (k < int'(LAST)) begin
          a_d[k] = a_in;
          b_d[k] = b_in;
          m_d[k] = m_in;
        end else begin
          ovf_d  = m_in ^ gc;
          zero_d = (s_in == '0);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      c_q    <= '0;
      m_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) s_q[k] <= '0;
      for (int k = 0; k < int'(PIPE); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      v_q    <= v_d;
      c_q    <= c_d;
      m_q    <= m_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      s_q    <= s_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe.sv
// Directed and streaming checks for cla_pipe at WIDTH=17, STAGES=2.
module tb_cla_pipe;
  localparam int unsigned W = 17;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf, zero;

  cla_pipe #(.WIDTH(W), .GROUP(4), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  vec_t vecs [13];
  exp_t q [$];
  int   checks = 0;
  int   errors = 0;
  int   n_in = 0;
  int   n_out = 0;
  logic prev_stall = 1'b0;
  logic [W+2:0] prev_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plain integer model: add, or subtract with borrow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
    logic [W:0] r;
    exp_t e;
    if (sb) r = {1'b0, a} - {1'b0, b} - (W+1)'(ci);
    else    r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    e.sum  = r[W-1:0];
    e.cout = sb ? ~r[W] : r[W];
    if (sb) e.ovf = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
    else    e.ovf = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    e.zero = (e.sum == '0);
    return e;
  endfunction

  // One clock of streaming traffic with scoreboard and stall-stability checks.
  task automatic run_cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sb, input logic ordy,
                           output logic fired, output logic ir);
    exp_t e;
    in_valid  = iv;
    op_a      = a;
    op_b      = b;
    cin       = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    ir    = in_ready;
    fired = iv & in_ready;
    if (prev_stall)
      check("stall_hold", {out_valid, sum, cout, ovf, zero}, {1'b1, prev_out});
    if (out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        e = q.pop_front();
        check($sformatf("stream_out%0d", n_out), {sum, cout, ovf, zero},
              {e.sum, e.cout, e.ovf, e.zero});
      end
    end
    if (fired) begin
      n_in++;
      q.push_back(model(a, b, ci, sb));
    end
    prev_stall = out_valid & ~out_ready;
    prev_out   = {sum, cout, ovf, zero};
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic         fired, ir;
    int           lat, cyc, issued, base_in, base_out;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{17'h1FFFF, 17'h00001, 1'b0, 1'b0, 17'h00000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{17'h00005, 17'h00007, 1'b0, 1'b1, 17'h1FFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{17'h00007, 17'h00005, 1'b1, 1'b1, 17'h00001, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{17'h0FFFF, 17'h00001, 1'b0, 1'b0, 17'h10000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{17'h10000, 17'h00001, 1'b0, 1'b1, 17'h0FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{17'h00000, 17'h00000, 1'b1, 1'b0, 17'h00001, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{17'h12345, 17'h0ABCD, 1'b0, 1'b0, 17'h1CF12, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{17'h1FFFF, 17'h1FFFF, 1'b1, 1'b0, 17'h1FFFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{17'h0ABCD, 17'h0ABCD, 1'b0, 1'b1, 17'h00000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{17'h00000, 17'h00000, 1'b1, 1'b1, 17'h1FFFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{17'h001FF, 17'h00001, 1'b0, 1'b0, 17'h00200, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{17'h10000, 17'h10000, 1'b0, 1'b0, 17'h00000, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{17'h0FFFF, 17'h1FFFF, 1'b0, 1'b1, 17'h10000, 1'b0, 1'b1, 1'b0};

    // Reset held three cycles with operands offered.
    rst = 1'b1; in_valid = 1'b1; op_a = 17'h00003; op_b = 17'h00004;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_out_valid%0d", i), 64'(out_valid), 64'(0));
      check($sformatf("rst_in_ready%0d", i), 64'(in_ready), 64'(1));
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    check("post_rst_outputs", {out_valid, sum, cout, ovf, zero}, 64'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_rst_idle%0d", i), 64'(out_valid), 64'(0));
    end

    // Directed table: one op at a time, latency and flags checked.
    foreach (vecs[i]) begin
      op_a = vecs[i].a; op_b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        step();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(S));
      check($sformatf("vec%0d_result", i), {sum, cout, ovf, zero},
            {vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero});
      step();
      check($sformatf("vec%0d_no_dup", i), 64'(out_valid), 64'(0));
    end

    // Backpressure: 8 back-to-back ops, consumer stalls in cycles 3..6.
    base_in = n_in; base_out = n_out; issued = 0; cyc = 0;
    while ((issued < 8 || q.size() != 0) && cyc < 40) begin
      ra = W'(32'h0F0F0 + issued * 32'h1111);
      rb = W'(32'h1E1E1 - issued * 32'h0777);
      run_cycle(issued < 8, ra, rb, 1'(issued), 1'(issued >> 1),
                !(cyc >= 3 && cyc <= 6), fired, ir);
      if (cyc < 8) check($sformatf("bp_in_ready_c%0d", cyc), 64'(ir),
                         64'(!(cyc >= 3 && cyc <= 6)));
      if (fired) issued++;
      cyc++;
    end
    check("bp_accepted", 64'(n_in - base_in), 64'(8));
    check("bp_emitted", 64'(n_out - base_out), 64'(8));

    // Reset with two ops held in the pipe: neither may surface.
    run_cycle(1'b1, 17'h00011, 17'h00022, 1'b0, 1'b0, 1'b0, fired, ir);
    run_cycle(1'b1, 17'h00033, 17'h00044, 1'b0, 1'b0, 1'b0, fired, ir);
    check("mid_rst_full", 64'(out_valid), 64'(1));
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    q.delete();
    prev_stall = 1'b0;
    base_out = n_out;
    for (int i = 0; i < 6; i++)
      run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, fired, ir);
    check("mid_rst_no_output", 64'(n_out - base_out), 64'(0));

    // Random valid/ready traffic against the integer model.
    base_in = n_in; base_out = n_out; cyc = 0;
    while (n_in - base_in < 2000 && cyc < 8000) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), 1'($urandom),
                $urandom_range(0, 3) != 0, fired, ir);
      cyc++;
    end
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      run_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, fired, ir);
      cyc++;
    end
    check("rand_accepted", 64'(n_in - base_in), 64'(2000));
    check("rand_drained", 64'(n_out - base_out), 64'(2000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
